// File: rtl/vga_pkg.sv
// Shared VGA/game definitions: active-window bounds, screen mode and layer
// encodings, colour constants and the per-pixel request bundle fed to the
// pixel arbiter.
package vga_pkg;

    localparam logic [9:0] ACT_X_MIN = 10'd144;
    localparam logic [9:0] ACT_X_MAX = 10'd783;
    localparam logic [9:0] ACT_Y_MIN = 10'd35;
    localparam logic [9:0] ACT_Y_MAX = 10'd514;

    typedef enum logic [1:0] {
        MODE_TITLE = 2'd0,
        MODE_PLAY  = 2'd1,
        MODE_OVER  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        LAYER_NONE   = 2'd0,
        LAYER_TEXT   = 2'd1,
        LAYER_SPRITE = 2'd2
    } layer_t;

    localparam logic [11:0] COL_BLACK = 12'h000;
    localparam logic [11:0] COL_WHITE = 12'hFFF;
    localparam logic [11:0] COL_RED   = 12'hF00;

    // Everything the arbiter needs about the current pixel.
    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        title;
        logic        over;
        logic        sprite;
        logic [11:0] sprite_rgb;
    } pix_req_t;

    function automatic logic in_active(input logic [9:0] x, input logic [9:0] y);
        return (x >= ACT_X_MIN) && (x <= ACT_X_MAX) &&
               (y >= ACT_Y_MIN) && (y <= ACT_Y_MAX);
    endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Signal bundle between the screen sequencer and the rest of the game.
//   xsync/ysync      : raw timing-generator counters
//   start/game_over  : player start level, one-cycle game-over event
//   *_px, sprite_rgb : per-pixel layer hits and sprite colour
//   mode             : current screen (0 TITLE, 1 PLAY, 2 OVER)
//   frame_tick/blink : frame-rate timing for game logic
//   rgb/layer_sel    : arbitrated pixel colour and granted layer
// slave = sequencer view, master = game/timing side view.
interface screen_sequencer_if;
    logic [9:0]  xsync;
    logic [9:0]  ysync;
    logic        start;
    logic        game_over;
    logic        title_px;
    logic        over_px;
    logic        sprite_px;
    logic [11:0] sprite_rgb;
    logic [1:0]  mode;
    logic        frame_tick;
    logic        blink;
    logic [11:0] rgb;
    logic [1:0]  layer_sel;

    modport slave (
        input  xsync, ysync, start, game_over, title_px, over_px, sprite_px, sprite_rgb,
        output mode, frame_tick, blink, rgb, layer_sel
    );

    modport master (
        output xsync, ysync, start, game_over, title_px, over_px, sprite_px, sprite_rgb,
        input  mode, frame_tick, blink, rgb, layer_sel
    );
endinterface

// File: rtl/pixel_mux.sv
// Pixel arbiter: blanks outside the active window, otherwise grants the
// layer that matches the current screen mode, and registers the result.
//   clk, clr   : pixel clock, async active-high reset
//   req        : current pixel coordinates, layer hits, sprite colour
//   mode,blink : current screen mode and blink phase
//   rgb        : registered colour, 1 cycle after req
//   layer_sel  : registered granted layer
module pixel_mux
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  pix_req_t    req,
    input  mode_t       mode,
    input  logic        blink,
    output logic [11:0] rgb,
    output layer_t      layer_sel
);

    logic [11:0] rgb_d;
    layer_t      layer_d;

    always_comb begin
        rgb_d   = COL_BLACK;
        layer_d = LAYER_NONE;
        if (in_active(req.x, req.y)) begin
            // Each mode owns exactly one foreground layer; hits from
            // other layers are ignored rather than prioritised.
            case (mode)
                MODE_PLAY: if (req.sprite) begin
                    rgb_d   = req.sprite_rgb;
                    layer_d = LAYER_SPRITE;
                end
                MODE_TITLE: if (req.title && blink) begin
                    rgb_d   = COL_WHITE;
                    layer_d = LAYER_TEXT;
                end
                MODE_OVER: if (req.over) begin
                    rgb_d   = COL_RED;
                    layer_d = LAYER_TEXT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rgb       <= COL_BLACK;
            layer_sel <= LAYER_NONE;
        end else begin
            rgb       <= rgb_d;
            layer_sel <= layer_d;
        end
    end

endmodule

// File: rtl/screen_sequencer.sv
// Frame-synchronous screen controller. Sequences TITLE -> PLAY -> OVER ->
// TITLE, changing screen only on the frame_tick edge, and produces frame
// and blink timing. Pixel arbitration is delegated to pixel_mux.
//   clk, clr : pixel clock, async active-high reset
//   bus      : screen_sequencer_if.slave (see interface header)
module screen_sequencer
    import vga_pkg::*;
#(
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int BLINK_FRAMES = 30,
    parameter int OVER_FRAMES  = 180
) (
    input logic               clk,
    input logic               clr,
    screen_sequencer_if.slave bus
);

    localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);

    mode_t      mode_q, mode_d;
    logic       frame_tick_q;
    logic       start_q;
    logic       start_pend;
    logic       over_pend;
    logic [7:0] over_cnt;
    logic [7:0] blink_cnt;
    logic       blink_q;
    logic       rise;
    logic       mode_chg;
    pix_req_t   pix_req;
    logic [11:0] rgb;
    layer_t     layer;

    assign rise     = bus.start & ~start_q;
    assign mode_chg = (mode_d != mode_q);

    // Next-state: only a frame_tick edge may move the screen. Pending
    // flags are sampled here before any same-cycle event can set them,
    // so an event coinciding with frame_tick waits one frame.
    always_comb begin
        mode_d = mode_q;
        if (frame_tick_q) begin
            case (mode_q)
                MODE_TITLE: if (start_pend)             mode_d = MODE_PLAY;
                MODE_PLAY:  if (over_pend)              mode_d = MODE_OVER;
                MODE_OVER:  if (over_cnt == OVER_LAST)  mode_d = MODE_TITLE;
                default:                                mode_d = MODE_TITLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) mode_q <= MODE_TITLE;
        else     mode_q <= mode_d;
    end

    // Frame tick lands on the counters' (0,0) cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            frame_tick_q <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            frame_tick_q <= (bus.xsync == X_LAST) && (bus.ysync == Y_LAST);
            start_q      <= bus.start;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            start_pend <= 1'b0;
            over_pend  <= 1'b0;
        end else if (mode_chg) begin
            start_pend <= 1'b0;
            over_pend  <= 1'b0;
        end else begin
            if (rise && mode_q == MODE_TITLE)         start_pend <= 1'b1;
            if (bus.game_over && mode_q == MODE_PLAY) over_pend  <= 1'b1;
        end
    end

    // over_cnt reads 0 on entry to OVER, so OVER spans OVER_FRAMES frames.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                                    over_cnt <= '0;
        else if (mode_chg)                          over_cnt <= '0;
        else if (frame_tick_q && mode_q == MODE_OVER) over_cnt <= over_cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (mode_chg) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (frame_tick_q) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_q   <= ~blink_q;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        pix_req            = '0;
        pix_req.x          = bus.xsync;
        pix_req.y          = bus.ysync;
        pix_req.title      = bus.title_px;
        pix_req.over       = bus.over_px;
        pix_req.sprite     = bus.sprite_px;
        pix_req.sprite_rgb = bus.sprite_rgb;
    end

    pixel_mux u_pixel_mux (
        .clk       (clk),
        .clr       (clr),
        .req       (pix_req),
        .mode      (mode_q),
        .blink     (blink_q),
        .rgb       (rgb),
        .layer_sel (layer)
    );

    assign bus.mode       = mode_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.blink      = blink_q;
    assign bus.rgb        = rgb;
    assign bus.layer_sel  = layer;

endmodule
